// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU datapath and its operand stage.
// Holds the datapath widths, the ALU opcode encoding and the operand-select flags.
// Imported by ex_operand_stage and fwd_sel; no logic lives here.
package alu_pkg;

  localparam int XLEN = 64;  // operand/data width
  localparam int RAW  = 5;   // register address width
  localparam int OPW  = 4;   // ALU opcode width

  typedef enum logic [OPW-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  // Operand-select flags carried with each entry
  typedef struct packed {
    logic use_pc;   // operand a = pc instead of rs1
    logic use_imm;  // operand b = imm instead of rs2
  } opsel_t;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding mux for one source operand: EX/MEM beats MEM/WB beats register file.
// Latency: purely combinational. Backpressure: none, no state.
// Ports: i_addr source index, i_rf_data default data, i_mem_*/i_wb_* bypass ports, o_data result.
module fwd_sel
  import alu_pkg::*;
(
  input  logic [RAW-1:0]  i_addr,
  input  logic [XLEN-1:0] i_rf_data,
  input  logic            i_mem_we,
  input  logic [RAW-1:0]  i_mem_rd,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_wb_we,
  input  logic [RAW-1:0]  i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic [XLEN-1:0] o_data
);

  logic w_nonzero;
  logic w_hit_mem;
  logic w_hit_wb;

  // x0 is hardwired zero in the register file, so a pending write to it must never bypass
  assign w_nonzero = (i_addr != '0);
  assign w_hit_mem = w_nonzero && i_mem_we && (i_mem_rd == i_addr);
  assign w_hit_wb  = w_nonzero && i_wb_we  && (i_wb_rd  == i_addr);

  always_comb begin
    o_data = i_rf_data;
    if (w_hit_mem) begin
      o_data = i_mem_data;       // youngest producer wins
    end else if (w_hit_wb) begin
      o_data = i_wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Execute-stage operand register: forwards, registers and presents ALU operands a/b.
// Latency: 1 cycle from accept to out_valid; full throughput on back-to-back accepts.
// Backpressure: in_ready = !flush && (!out_valid || out_ready); held sources refresh from bypass while stalled.
// Ports: decode side in_*, bypass fwd_mem_*/fwd_wb_*, ALU side out_* with out_valid/out_ready, flush kills held entry.
module ex_operand_stage
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RAW-1:0]  in_rs1_addr,
  input  logic [RAW-1:0]  in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_use_imm,
  input  logic            in_use_pc,
  input  logic [OPW-1:0]  in_alu_op,
  input  logic [RAW-1:0]  in_rd_addr,
  input  logic            fwd_mem_we,
  input  logic [RAW-1:0]  fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_we,
  input  logic [RAW-1:0]  fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_rs2,
  output logic [OPW-1:0]  out_alu_op,
  output logic [RAW-1:0]  out_rd_addr
);

  logic            r_valid;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;
  opsel_t          r_sel;
  logic [OPW-1:0]  r_op;
  logic [RAW-1:0]  r_rd;
  logic [RAW-1:0]  r_rs1_addr;
  logic [RAW-1:0]  r_rs2_addr;

  logic            w_accept;
  logic            w_refresh;
  logic [XLEN-1:0] w_cap_rs1;
  logic [XLEN-1:0] w_cap_rs2;
  logic [XLEN-1:0] w_ref_rs1;
  logic [XLEN-1:0] w_ref_rs2;

  assign in_ready  = !flush && (!r_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  // A stalled entry keeps watching the bypass ports so it never goes stale
  assign w_refresh = r_valid && !out_ready && !flush;

  fwd_sel u_cap_rs1 (
    .i_addr(in_rs1_addr), .i_rf_data(in_rs1_data),
    .i_mem_we(fwd_mem_we), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_we(fwd_wb_we), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_data(w_cap_rs1)
  );

  fwd_sel u_cap_rs2 (
    .i_addr(in_rs2_addr), .i_rf_data(in_rs2_data),
    .i_mem_we(fwd_mem_we), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_we(fwd_wb_we), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_data(w_cap_rs2)
  );

  // Refresh muxes default to the held value, so no bypass hit means no change
  fwd_sel u_ref_rs1 (
    .i_addr(r_rs1_addr), .i_rf_data(r_rs1),
    .i_mem_we(fwd_mem_we), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_we(fwd_wb_we), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_data(w_ref_rs1)
  );

  fwd_sel u_ref_rs2 (
    .i_addr(r_rs2_addr), .i_rf_data(r_rs2),
    .i_mem_we(fwd_mem_we), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_we(fwd_wb_we), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_data(w_ref_rs2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_sel      <= '0;
      r_op       <= '0;
      r_rd       <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid       <= 1'b1;
      r_rs1         <= w_cap_rs1;
      r_rs2         <= w_cap_rs2;
      r_imm         <= in_imm;
      r_pc          <= in_pc;
      r_sel.use_pc  <= in_use_pc;
      r_sel.use_imm <= in_use_imm;
      r_op          <= in_alu_op;
      r_rd          <= in_rd_addr;
      r_rs1_addr    <= in_rs1_addr;
      r_rs2_addr    <= in_rs2_addr;
    end else if (w_refresh) begin
      r_rs1 <= w_ref_rs1;
      r_rs2 <= w_ref_rs2;
    end else if (out_ready) begin
      // Consumed with nothing new behind it: drop valid, keep data
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_a       = r_sel.use_pc  ? r_pc  : r_rs1;
  assign out_b       = r_sel.use_imm ? r_imm : r_rs2;
  assign out_rs2     = r_rs2;
  assign out_alu_op  = r_op;
  assign out_rd_addr = r_rd;

endmodule
